// File: rtl/otter_fetch_pkg.sv
// -----------------------------------------------------------------------------
// otter_fetch_pkg
// Shared types and constants for the OTTER instruction-fetch front end.
//   fetch_entry_t    : one prefetched instruction together with its PC
//   OTTER_NOP        : ADDI x0,x0,0; decode substitutes this when de_valid=0
//   DEFAULT_RESET_PC : default fetch PC after reset
// Optional build macro used by the fetch queue: OTTER_FETCH_PERF_EN
// -----------------------------------------------------------------------------
package otter_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    localparam logic [31:0] OTTER_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/otter_fetch_fifo.sv
// -----------------------------------------------------------------------------
// otter_fetch_fifo
// Synchronous prefetch FIFO of fetch_entry_t. DEPTH must be a power of two so
// the pointers wrap for free. Flush empties the FIFO and has priority over
// push and pop; RESET additionally clears the storage.
// Ports:
//   CLK, RESET      : clock, synchronous active-high reset
//   flush           : drop all entries, pointers back to 0
//   push, push_data : write one entry at wr_ptr
//   pop             : retire the head entry
//   head            : entry at rd_ptr
//   count           : number of stored entries, 0..DEPTH
//   full, empty     : count==DEPTH, count==0
// -----------------------------------------------------------------------------
module otter_fetch_fifo
    import otter_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/otter_fetch_queue.sv
// -----------------------------------------------------------------------------
// otter_fetch_queue
// Fetch front end for the pipelined OTTER. Owns the fetch PC, issues reads to
// instruction-memory port 1 (one-cycle synchronous read), buffers returned
// words with their PCs in a prefetch FIFO and hands them to decode over a
// valid/ready handshake. A redirect flushes all queued and in-flight fetches.
// Ports:
//   CLK, RESET            : clock, synchronous active-high reset
//   imem_rd, imem_addr    : read strobe and address to memory port 1
//   imem_data             : word returned the cycle after imem_rd
//   redirect, redirect_pc : one-cycle flush/restart request and target PC
//   de_valid, de_ready    : handshake to decode
//   de_pc, de_ir          : PC and instruction of the head entry
//   perf_fetched/flushed/starve : event counters, present only when the
//                           OTTER_FETCH_PERF_EN macro is defined
// -----------------------------------------------------------------------------
module otter_fetch_queue
    import otter_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_rd,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        de_valid,
    input  logic        de_ready,
    output logic [31:0] de_pc,
`ifdef OTTER_FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_starve,
`endif
    output logic [31:0] de_ir
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic          r_inflight_q;
    logic [31:0]   r_inflight_pc;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_outstanding;
    logic          w_credit;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic          w_unused;

    // Target is word aligned; the low two bits of redirect_pc are ignored.
    assign w_unused = ^redirect_pc[1:0];

    // Credit: a read is only issued when its response is guaranteed a slot,
    // counting the one already in flight. This is what makes overflow
    // impossible without any back-pressure on the memory side.
    assign w_outstanding = (CW+1)'(w_count) + (CW+1)'(r_inflight_q);
    assign w_credit      = (w_outstanding < (CW+1)'(DEPTH));

    assign imem_rd   = !RESET && !redirect && w_credit;
    assign imem_addr = RESET ? RESET_PC : r_fetch_pc;

    assign w_push      = r_inflight_q && !redirect && !RESET;
    assign w_push_data = '{pc: r_inflight_pc, ir: imem_data};

    assign de_valid = !w_empty && !redirect && !RESET;
    assign w_pop    = de_valid && de_ready;
    assign de_pc    = RESET ? 32'h0 : w_head.pc;
    assign de_ir    = RESET ? 32'h0 : w_head.ir;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_q  <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect) begin
            r_fetch_pc    <= {redirect_pc[31:2], 2'b00};
            r_inflight_q  <= 1'b0;
        end else begin
            r_inflight_q <= imem_rd;
            if (imem_rd) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    otter_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .flush     (redirect),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always @(posedge CLK) begin
        if (!RESET) begin
            assert (!(w_push && w_full));
        end
    end

`ifdef OTTER_FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic [31:0] r_perf_starve;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
            r_perf_starve  <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            // Queued entries plus the response arriving this cycle are lost.
            if (redirect) begin
                r_perf_flushed <= r_perf_flushed + 32'(w_count) + 32'(r_inflight_q);
            end
            if (de_ready && !de_valid) begin
                r_perf_starve <= r_perf_starve + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
    assign perf_starve  = r_perf_starve;
`endif

endmodule

// File: tb/tb_otter_fetch_queue.sv
module tb_otter_fetch_queue;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        de_valid;
    logic        de_ready = 1'b1;
    logic [31:0] de_pc;
    logic [31:0] de_ir;
`ifdef OTTER_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] perf_starve;
    logic [31:0] flushed_snap;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    always #5 CLK = ~CLK;

    otter_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .de_valid    (de_valid),
        .de_ready    (de_ready),
        .de_pc       (de_pc),
`ifdef OTTER_FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
        .perf_starve (perf_starve),
`endif
        .de_ir       (de_ir)
    );

    // Memory port 1: one-cycle synchronous read; junk when no read was issued.
    always @(posedge CLK) begin
        imem_data <= imem_rd ? (imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then move to the
    // falling edge where outputs are sampled.
    task automatic step(input logic rst, input logic rdy, input logic rdr, input logic [31:0] rpc);
        @(posedge CLK);
        #1;
        RESET       = rst;
        de_ready    = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        @(negedge CLK);
    endtask

    task automatic expect_pcs(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Scoreboard monitor: every accepted handshake must match the next
    // expected PC, and the word must be the memory pattern for that PC.
    always @(negedge CLK) begin
        if (de_valid === 1'b1 && de_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got pc %h expected no transfer", de_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", de_pc, e);
                check("sb_ir", de_ir, e ^ 32'hA5A5_0000);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int issues;

        // Reset state
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("rst_imem_rd", 32'(imem_rd), 0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_de_valid", 32'(de_valid), 0);
        check("rst_de_pc", de_pc, 0);
        check("rst_de_ir", de_ir, 0);

        // 1: streaming with de_ready=1
        expect_pcs(32'h0, 8);
        step(0, 1, 0, 0);
        check("t1_rd0", 32'(imem_rd), 1);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_valid0", 32'(de_valid), 0);
        step(0, 1, 0, 0);
        check("t1_addr1", imem_addr, 32'h4);
        check("t1_valid1", 32'(de_valid), 0);
        step(0, 1, 0, 0);
        check("t1_valid2", 32'(de_valid), 1);
        check("t1_pc2", de_pc, 32'h0);
        check("t1_ir2", de_ir, 32'hA5A5_0000);
        check("t1_addr2", imem_addr, 32'h8);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 0, 0);
            check("t1_nogap", 32'(de_valid), 1);
            check("t1_addr_seq", imem_addr, 32'(12 + 4 * i));
        end

        // 2: stall decode from reset; exactly DEPTH fetches, then drain
        step(1, 0, 0, 0);
        check("t2_rst_valid", 32'(de_valid), 0);
        issues = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            if (imem_rd) issues++;
        end
        check("t2_issues", 32'(issues), 4);
        check("t2_rd_held", 32'(imem_rd), 0);
        check("t2_head_pc", de_pc, 32'h0);
        expect_pcs(32'h0, 10);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

        // 3: three queued, one in flight, redirect to 0x100
        step(0, 0, 0, 0);
`ifdef OTTER_FETCH_PERF_EN
        flushed_snap = perf_flushed;
`endif
        step(0, 0, 1, 32'h100);
        check("t3_valid_redir", 32'(de_valid), 0);
        check("t3_rd_redir", 32'(imem_rd), 0);
        expect_pcs(32'h100, 4);
        step(0, 1, 0, 0);
        check("t3_addr", imem_addr, 32'h100);
        check("t3_rd", 32'(imem_rd), 1);
`ifdef OTTER_FETCH_PERF_EN
        check("t3_perf_flushed", perf_flushed - flushed_snap, 32'd4);
`endif
        step(0, 1, 0, 0);
        check("t3_valid_gap", 32'(de_valid), 0);
        step(0, 1, 0, 0);
        check("t3_first_pc", de_pc, 32'h100);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

        // 4: misaligned redirect target
        step(0, 1, 1, 32'h102);
        check("t4_valid_redir", 32'(de_valid), 0);
        expect_pcs(32'h100, 2);
        step(0, 1, 0, 0);
        check("t4_addr_aligned", imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

        // 5: fill the queue, then reset for one cycle
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("t5_full_rd", 32'(imem_rd), 0);
        check("t5_full_valid", 32'(de_valid), 1);
        step(1, 0, 0, 0);
        check("t5_rst_valid", 32'(de_valid), 0);
        check("t5_rst_rd", 32'(imem_rd), 0);
        check("t5_rst_addr", imem_addr, 32'h0);
        check("t5_rst_pc", de_pc, 32'h0);
        expect_pcs(32'h0, 2);
        step(0, 1, 0, 0);
        check("t5_valid_after", 32'(de_valid), 0);
        check("t5_addr_after", imem_addr, 32'h0);
        check("t5_rd_after", 32'(imem_rd), 1);
        step(0, 1, 0, 0);
        check("t5_valid_gap", 32'(de_valid), 0);
        step(0, 1, 0, 0);
        check("t5_first_pc", de_pc, 32'h0);
        step(0, 1, 0, 0);

        // 6: redirect near the top of the address space; PC wraps
        step(0, 1, 1, 32'hFFFF_FFFC);
        check("t6_valid_redir", 32'(de_valid), 0);
        expect_pcs(32'hFFFF_FFFC, 3);
        step(0, 1, 0, 0);
        check("t6_addr0", imem_addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0);
        check("t6_addr1", imem_addr, 32'h0);
        step(0, 1, 0, 0);
        check("t6_pc0", de_pc, 32'hFFFF_FFFC);
        step(0, 1, 0, 0);
        check("t6_pc1", de_pc, 32'h0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("sb_leftover", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/otter_fetch_queue.md
Name: otter_fetch_queue

Overview:
Instruction-fetch front end for the pipelined OTTER. Owns the fetch PC and drives instruction memory port 1, which has a fixed one-cycle synchronous read. It buffers returned words with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake. It accepts a redirect from the branch/jump resolution logic; a redirect flushes every queued and in-flight fetch.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
CLK  in  1  clock; all state updates on the rising edge
RESET  in  1  synchronous, active-high reset
imem_rd  out  1  read strobe to memory port 1
imem_addr  out  32  read address (current fetch PC)
imem_data  in  32  instruction word, valid in the cycle after imem_rd=1
redirect  in  1  flush and restart fetch; single-cycle pulse
redirect_pc  in  32  new fetch PC when redirect=1
de_valid  out  1  head entry available to decode
de_ready  in  1  decode accepts the head entry this cycle
de_pc  out  32  PC of the head entry
de_ir  out  32  instruction word of the head entry

Behaviour:
- Interface: one clock, CLK. RESET is synchronous and active-high.
- No explicit FSM. State is fetch_pc, inflight_q (1 bit), inflight_pc, FIFO storage, rd_ptr, wr_ptr and count (0..DEPTH).
- Reset values: fetch_pc=RESET_PC, inflight_q=0, count=0, pointers=0, storage=0. With RESET=1: imem_rd=0, imem_addr=RESET_PC, de_valid=0, de_pc=0, de_ir=0.
- imem_addr = fetch_pc, combinational from the register.
- imem_rd = !RESET && !redirect && (count + inflight_q < DEPTH). This credit rule makes overflow impossible. Add an assertion that a push never occurs with count==DEPTH.
- Issue (imem_rd=1): fetch_pc <= fetch_pc+4, wrapping mod 2^32; inflight_q <= 1; inflight_pc <= fetch_pc. No issue: inflight_q <= 0.
- Response: in a cycle with inflight_q=1 and redirect=0, push {inflight_pc, imem_data} at the clock edge.
- Latency: imem_rd in cycle N gives de_valid in cycle N+2. There is no bypass from imem_data to de_ir.
- Throughput: one instruction per cycle is sustained while de_ready=1.
- Output: de_valid = (count!=0) && !redirect. de_pc/de_ir come from the rd_ptr entry. Pop when de_valid && de_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap mod DEPTH.
- Redirect cycle, in effect on the next clock edge:
  - count <= 0 and rd_ptr=wr_ptr=0.
  - The arriving response is discarded.
  - inflight_q <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No issue and no pop occur in the redirect cycle.
  - The next cycle issues from the new PC.
- Redirect has priority over push, pop and issue.
- RESET asserted mid-stream has the same flush effect, with fetch_pc <= RESET_PC. Any in-flight response is discarded.
- de_ready with de_valid=0 has no effect. de_pc/de_ir are don't-care when de_valid=0.

Optional Feature:
OTTER_FETCH_PERF_EN
- Defined: adds outputs perf_fetched (32 bits, pushes), perf_flushed (32 bits, queued entries plus the in-flight response discarded by redirect) and perf_starve (32 bits, cycles with de_ready=1 and de_valid=0).
- Counters reset to 0 on RESET and wrap mod 2^32.
- Not defined: these ports and counters are absent, and functional behaviour is identical.

Decomposition:
- Package otter_fetch_pkg:
  - fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] ir;}
  - OTTER_NOP = 32'h0000_0013, for decode to use when invalid
  - DEFAULT_RESET_PC
- One sub-module, otter_fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty. Flush has priority over push and pop.
- Fetch-PC, credit and redirect logic stay in otter_fetch_queue.

Test Plan:
1. Release RESET with de_ready=1; memory model returns imem_data=addr^32'hA5A5_0000.
   -> imem_addr sequence 0,4,8,...; first de_valid two cycles after the first imem_rd with de_pc=0, de_ir=32'hA5A5_0000; then one entry per cycle, with no gaps.
2. Hold de_ready=0.
   -> Exactly DEPTH=4 pushes occur, then imem_rd stays 0.
   -> On setting de_ready=1, PCs 0,4,8,12 drain in order and 16 follows without loss.
3. With 3 queued entries and one in flight, pulse redirect with redirect_pc=32'h100.
   -> de_valid=0 in that cycle; the next issue is at 0x100.
   -> The next de_pc is 0x100; PCs from before the redirect never appear.
   -> perf_flushed increases by 4.
4. Pulse redirect with redirect_pc=32'h102.
   -> imem_addr=32'h100 the following cycle.
5. Assert RESET for one cycle while the queue is full.
   -> Next cycle: de_valid=0, imem_addr=RESET_PC; the stale response is never pushed.
6. Redirect to 32'hFFFF_FFFC.
   -> Issued addresses 0xFFFFFFFC then 0x00000000; de_pc follows the same wrap.
